tlb_op_ctrl: RTL and testbench
==============================

// Module: tlb_op_ctrl
// PURPOSE
//  Sequences the CP0 TLB instructions TLBR, TLBWI, TLBWR and TLBP against the 16-entry TLB array.
//  Accepts one op at a time from the pipeline and drives the TLB write port.
//  Drives the TLB read-index port and scans for TLBP.
//  Maintains the CP0 Random and Wired registers and returns probe and read results to CP0.
// PARAMETERS
//  NENTRY   16  TLB entries; index width IW = 4 (fixed)
//  VPN2_W   19  VPN2 field width
//  LO_W     26  per-page EntryLo field width: {PFN[23:0], D, V}
// PORTS
//  clk            in   1   rising-edge clock
//  rst_n          in   1   asynchronous, active-low reset
//  op_valid       in   1   op request from pipeline
//  op_code        in   2   00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP
//  op_ready       out  1   high only in IDLE; op accepted when op_valid & op_ready
//  busy           out  1   ~IDLE (pipeline stall)
//  done           out  1   one-cycle completion pulse
//  index_in       in   4   CP0 Index, used by TLBR/TLBWI
//  entryhi_vpn2   in   19  CP0 EntryHi VPN2
//  entrylo1       in   26  CP0 EntryLo1 {PFN, D, V}
//  entrylo0       in   26  CP0 EntryLo0 {PFN, D, V}
//  wired_we       in   1   write Wired register
//  wired_in       in   4   new Wired value
//  tlb_we         out  1   TLB write strobe
//  tlb_wr_index   out  4   TLB write index
//  tlb_wr_entry   out  71  {vpn2[70:52], lo1[51:26], lo0[25:0]}
//  tlb_rd_index   out  4   TLB read index
//  tlb_rd_entry   in   71  combinational read data for tlb_rd_index
//  rd_entry_out   out  71  TLBR result; held until next TLBR completes
//  probe_miss     out  1   TLBP result: 1 = no match
//  probe_index    out  4   TLBP matching index (valid when probe_miss = 0)
//  random_out     out  4   CP0 Random
//  wired_out      out  4   CP0 Wired
// BEHAVIOUR
//  Reset values:
//   - state IDLE, op_ready 1, busy 0, done 0, tlb_we 0
//   - tlb_wr_index 0, tlb_wr_entry 0, tlb_rd_index 0, rd_entry_out 0
//   - probe_miss 1, probe_index 0, random_out 15, wired_out 0
//  All outputs are registered, except op_ready, busy and tlb_we, which decode state.
//  States: IDLE, WRITE, READ, PROBE, DONE.
//  On accept in cycle T, latch op_code, index, VPN2, EntryLo0/1 and Random (captured at T).
//  Later CP0 changes do not affect the op in flight.
//  TLBWI / TLBWR:
//   - T+1 WRITE: tlb_we = 1 for exactly one cycle.
//   - tlb_wr_index = latched Index (TLBWI) or latched Random (TLBWR).
//   - T+2 DONE: done = 1.
//   - T+3 IDLE.
//  TLBR:
//   - T+1 READ: tlb_rd_index = latched Index; tlb_rd_entry captured into rd_entry_out.
//   - T+2 DONE: rd_entry_out valid.
//  TLBP:
//   - PROBE scans one entry per cycle: cycle T+1+k drives tlb_rd_index = k.
//   - Match when tlb_rd_entry[70:52] == latched VPN2.
//   - First match at k: probe_index = k, probe_miss = 0, DONE at T+2+k (lowest index wins).
//   - No match after k = 15: probe_miss = 1, probe_index unchanged, DONE at T+17.
//   - probe_miss/probe_index update only on TLBP completion.
//  DONE always returns to IDLE, so the minimum op spacing is 3 cycles (accept, WRITE/READ, DONE).
//  Random:
//   - Every cycle: if random == wired, next = 15; else random - 1.
//   - If wired = 15, Random stays at 15.
//   - wired_we: wired <= wired_in and random <= 15 in the same edge; this overrides the decrement.
//   - wired_we is legal in any state and does not alter the latched TLBWR index.
//  op_valid while busy is ignored (not queued); the requester holds it.
//  Async reset mid-op:
//   - Immediately returns to IDLE and drops tlb_we; no partial write completes.
//   - Random resets to 15 and Wired to 0.
//  Unknown-free: tlb_rd_index stays at its last value in IDLE/DONE.
// TESTING
//  1. TLBWI: index_in=5, vpn2=0x1234, lo1=0x2AAAAAA, lo0=0x1555555
//     -> tlb_we high exactly at T+1, tlb_wr_index=5, entry={0x1234,lo1,lo0}, done at T+2.
//  2. Random/Wired: after reset, Random sequence 15,14,...,0,15.
//     wired_we with 12 -> Random 15,14,13,12,15.
//     TLBWR accepted while Random=13 -> write index 13.
//  3. TLBP hit: entries 3 and 9 hold vpn2=0x00ABC, probe 0x00ABC
//     -> probe_index=3, probe_miss=0, done at T+5.
//  4. TLBP miss: no entry matches -> probe_miss=1, done at T+17, probe_index retains its old value.
//  5. TLBR: index_in=9 after a TLBWI to entry 9 -> rd_entry_out equals the written entry at done (T+2).
//  6. Reset: assert rst_n=0 at T+1 of TLBWI -> tlb_we falls immediately, no write, no done, state IDLE.
//     Back-to-back ops with op_valid held -> second op accepted at T+3.

Source files
------------

// File: rtl/tlb_op_ctrl.sv
// rtl/tlb_op_ctrl.sv - CP0 TLB instruction sequencer (TLBR/TLBWI/TLBWR/TLBP) with Random/Wired
//
// Accepts one TLB op at a time from the pipeline, drives the TLB write port for
// TLBWI/TLBWR, reads one entry for TLBR, linearly scans all 16 entries for TLBP,
// and maintains the CP0 Random and Wired registers.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   op_valid, op_code, op_ready    op handshake (00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP)
//   busy, done                     stall indication, one-cycle completion pulse
//   index_in, entryhi_vpn2,
//   entrylo1, entrylo0             CP0 operands, latched on accept
//   wired_we, wired_in             Wired register write
//   tlb_we, tlb_wr_index,
//   tlb_wr_entry                   TLB write port
//   tlb_rd_index, tlb_rd_entry     TLB read port (combinational read data)
//   rd_entry_out                   TLBR result
//   probe_miss, probe_index        TLBP result
//   random_out, wired_out          CP0 Random / Wired
module tlb_op_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [1:0]  op_code,
    output logic        op_ready,
    output logic        busy,
    output logic        done,
    input  logic [3:0]  index_in,
    input  logic [18:0] entryhi_vpn2,
    input  logic [25:0] entrylo1,
    input  logic [25:0] entrylo0,
    input  logic        wired_we,
    input  logic [3:0]  wired_in,
    output logic        tlb_we,
    output logic [3:0]  tlb_wr_index,
    output logic [70:0] tlb_wr_entry,
    output logic [3:0]  tlb_rd_index,
    input  logic [70:0] tlb_rd_entry,
    output logic [70:0] rd_entry_out,
    output logic        probe_miss,
    output logic [3:0]  probe_index,
    output logic [3:0]  random_out,
    output logic [3:0]  wired_out
);

    localparam int NENTRY = 16;
    localparam int IW     = 4;
    localparam logic [IW-1:0] LAST_IDX = IW'(NENTRY - 1);

    localparam logic [1:0] OP_TLBR  = 2'b00;
    localparam logic [1:0] OP_TLBWI = 2'b01;
    localparam logic [1:0] OP_TLBWR = 2'b10;
    localparam logic [1:0] OP_TLBP  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_PROBE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [IW-1:0] wr_index_q,    wr_index_d;
    logic [70:0]   wr_entry_q,    wr_entry_d;
    logic [IW-1:0] rd_index_q,    rd_index_d;
    logic [18:0]   vpn2_q,        vpn2_d;
    logic [70:0]   rd_entry_q,    rd_entry_d;
    logic          probe_miss_q,  probe_miss_d;
    logic [IW-1:0] probe_index_q, probe_index_d;
    logic          done_q,        done_d;
    logic [IW-1:0] random_q,      random_d;
    logic [IW-1:0] wired_q,       wired_d;

    logic accept;
    logic probe_hit;

    assign accept    = op_valid && (state_q == S_IDLE);
    assign probe_hit = (tlb_rd_entry[70:52] == vpn2_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op_code)
                        OP_TLBR:  state_d = S_READ;
                        OP_TLBP:  state_d = S_PROBE;
                        default:  state_d = S_WRITE;
                    endcase
                end
            end
            S_WRITE: state_d = S_DONE;
            S_READ:  state_d = S_DONE;
            // Stop on the first (lowest) matching index or after the last entry.
            S_PROBE: begin
                if (probe_hit || (rd_index_q == LAST_IDX)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        op_ready = (state_q == S_IDLE);
        busy     = (state_q != S_IDLE);
        tlb_we   = (state_q == S_WRITE);
    end

    // Datapath next-state
    always_comb begin
        wr_index_d    = wr_index_q;
        wr_entry_d    = wr_entry_q;
        rd_index_d    = rd_index_q;
        vpn2_d        = vpn2_q;
        rd_entry_d    = rd_entry_q;
        probe_miss_d  = probe_miss_q;
        probe_index_d = probe_index_q;

        if (accept) begin
            vpn2_d = entryhi_vpn2;
            case (op_code)
                OP_TLBR: rd_index_d = index_in;
                OP_TLBWI: begin
                    wr_index_d = index_in;
                    wr_entry_d = {entryhi_vpn2, entrylo1, entrylo0};
                end
                // Random is sampled in the accept cycle; later Wired writes
                // cannot move the target of a TLBWR already in flight.
                OP_TLBWR: begin
                    wr_index_d = random_q;
                    wr_entry_d = {entryhi_vpn2, entrylo1, entrylo0};
                end
                OP_TLBP: rd_index_d = '0;
                default: ;
            endcase
        end

        if (state_q == S_READ) begin
            rd_entry_d = tlb_rd_entry;
        end

        if (state_q == S_PROBE) begin
            if (probe_hit) begin
                probe_index_d = rd_index_q;
                probe_miss_d  = 1'b0;
            end else if (rd_index_q == LAST_IDX) begin
                probe_miss_d  = 1'b1;
            end else begin
                rd_index_d    = rd_index_q + 4'd1;
            end
        end

        done_d = (state_d == S_DONE);

        // Random counts down from 15 to Wired, then wraps back to 15.
        wired_d = wired_q;
        if (wired_we) begin
            wired_d  = wired_in;
            random_d = LAST_IDX;
        end else if (random_q == wired_q) begin
            random_d = LAST_IDX;
        end else begin
            random_d = random_q - 4'd1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_index_q    <= '0;
            wr_entry_q    <= '0;
            rd_index_q    <= '0;
            vpn2_q        <= '0;
            rd_entry_q    <= '0;
            probe_miss_q  <= 1'b1;
            probe_index_q <= '0;
            done_q        <= 1'b0;
            random_q      <= LAST_IDX;
            wired_q       <= '0;
        end else begin
            wr_index_q    <= wr_index_d;
            wr_entry_q    <= wr_entry_d;
            rd_index_q    <= rd_index_d;
            vpn2_q        <= vpn2_d;
            rd_entry_q    <= rd_entry_d;
            probe_miss_q  <= probe_miss_d;
            probe_index_q <= probe_index_d;
            done_q        <= done_d;
            random_q      <= random_d;
            wired_q       <= wired_d;
        end
    end

    assign done         = done_q;
    assign tlb_wr_index = wr_index_q;
    assign tlb_wr_entry = wr_entry_q;
    assign tlb_rd_index = rd_index_q;
    assign rd_entry_out = rd_entry_q;
    assign probe_miss   = probe_miss_q;
    assign probe_index  = probe_index_q;
    assign random_out   = random_q;
    assign wired_out    = wired_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb/tb_tlb_op_ctrl.sv - self-checking bench for tlb_op_ctrl
module tb_tlb_op_ctrl;

    localparam logic [1:0] OP_R  = 2'b00;
    localparam logic [1:0] OP_WI = 2'b01;
    localparam logic [1:0] OP_WR = 2'b10;
    localparam logic [1:0] OP_P  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [1:0]  op_code = 2'b00;
    logic        op_ready, busy, done;
    logic [3:0]  index_in = 4'd0;
    logic [18:0] entryhi_vpn2 = 19'd0;
    logic [25:0] entrylo1 = 26'd0;
    logic [25:0] entrylo0 = 26'd0;
    logic        wired_we = 1'b0;
    logic [3:0]  wired_in = 4'd0;
    logic        tlb_we;
    logic [3:0]  tlb_wr_index;
    logic [70:0] tlb_wr_entry;
    logic [3:0]  tlb_rd_index;
    logic [70:0] tlb_rd_entry;
    logic [70:0] rd_entry_out;
    logic        probe_miss;
    logic [3:0]  probe_index;
    logic [3:0]  random_out;
    logic [3:0]  wired_out;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;
    bit rand_wired = 1'b0;

    always #5 clk = ~clk;

    tlb_op_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
        .busy(busy), .done(done),
        .index_in(index_in), .entryhi_vpn2(entryhi_vpn2),
        .entrylo1(entrylo1), .entrylo0(entrylo0),
        .wired_we(wired_we), .wired_in(wired_in),
        .tlb_we(tlb_we), .tlb_wr_index(tlb_wr_index), .tlb_wr_entry(tlb_wr_entry),
        .tlb_rd_index(tlb_rd_index), .tlb_rd_entry(tlb_rd_entry),
        .rd_entry_out(rd_entry_out), .probe_miss(probe_miss), .probe_index(probe_index),
        .random_out(random_out), .wired_out(wired_out)
    );

    // TLB array environment
    logic [70:0] mem [16];
    assign tlb_rd_entry = mem[tlb_rd_index];
    always @(posedge clk) if (tlb_we) mem[tlb_wr_index] <= tlb_wr_entry;

    // Reference model state
    logic [70:0] ref_mem [16];
    logic [3:0]  rnd_m = 4'd15;
    logic [3:0]  wired_m = 4'd0;
    logic        pm_m = 1'b1;
    logic [3:0]  pi_m = 4'd0;
    logic [70:0] rd_m = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_m   <= 4'd15;
            wired_m <= 4'd0;
        end else if (wired_we) begin
            wired_m <= wired_in;
            rnd_m   <= 4'd15;
        end else if (rnd_m == wired_m) begin
            rnd_m   <= 4'd15;
        end else begin
            rnd_m   <= rnd_m - 4'd1;
        end
    end

    task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("random_mon", 71'(random_out), 71'(rnd_m));
            chk("wired_mon", 71'(wired_out), 71'(wired_m));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        wired_we = 1'b0;
        if (rand_wired && ($urandom_range(0, 19) == 0)) begin
            wired_we = 1'b1;
            wired_in = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic run_op(input logic [1:0] code, input logic [3:0] idx, input logic [18:0] vpn,
                          input logic [25:0] l1, input logic [25:0] l0,
                          output int lat, output int we_cnt, output logic [3:0] widx,
                          output logic [70:0] went, output logic [3:0] cap);
        int n = 0;
        while (!op_ready && n < 40) begin
            step();
            n++;
        end
        chk("op_ready_wait", 71'(op_ready), 71'(1));
        op_valid = 1'b1;
        op_code = code;
        index_in = idx;
        entryhi_vpn2 = vpn;
        entrylo1 = l1;
        entrylo0 = l0;
        cap = rnd_m;
        step();
        op_valid = 1'b0;
        index_in = 4'($urandom);
        entryhi_vpn2 = 19'($urandom);
        entrylo1 = 26'($urandom);
        entrylo0 = 26'($urandom);
        lat = 1;
        we_cnt = 0;
        widx = 4'd0;
        went = '0;
        while (!done && lat < 40) begin
            if (tlb_we) begin
                we_cnt++;
                widx = tlb_wr_index;
                went = tlb_wr_entry;
            end
            step();
            lat++;
        end
    endtask

    task automatic do_and_check(input logic [1:0] code, input logic [3:0] idx, input logic [18:0] vpn,
                                input logic [25:0] l1, input logic [25:0] l0,
                                output int lat, output logic [3:0] widx, output logic [70:0] went);
        int we_cnt;
        int xlat;
        int hk;
        bit hit;
        logic [3:0] cap;
        logic [3:0] xw;
        run_op(code, idx, vpn, l1, l0, lat, we_cnt, widx, went, cap);
        xlat = 2;
        if (code == OP_WI || code == OP_WR) begin
            xw = (code == OP_WI) ? idx : cap;
            chk("write_count", 71'(we_cnt), 71'(1));
            chk("write_index", 71'(widx), 71'(xw));
            chk("write_entry", went, {vpn, l1, l0});
            ref_mem[xw] = {vpn, l1, l0};
        end else begin
            chk("no_write", 71'(we_cnt), 71'(0));
        end
        if (code == OP_R) rd_m = ref_mem[idx];
        if (code == OP_P) begin
            hit = 1'b0;
            hk = 0;
            for (int k = 0; k < 16; k++) begin
                if (!hit && ref_mem[k][70:52] == vpn) begin
                    hit = 1'b1;
                    hk = k;
                end
            end
            xlat = hit ? hk + 2 : 17;
            if (hit) begin
                pm_m = 1'b0;
                pi_m = 4'(hk);
            end else begin
                pm_m = 1'b1;
            end
        end
        chk("latency", 71'(lat), 71'(xlat));
        chk("probe_miss", 71'(probe_miss), 71'(pm_m));
        chk("probe_index", 71'(probe_index), 71'(pi_m));
        chk("rd_entry_out", rd_entry_out, rd_m);
    endtask

    typedef struct {
        logic [1:0]  code;
        logic [3:0]  idx;
        logic [18:0] vpn;
        logic [25:0] l1;
        logic [25:0] l0;
        int          lat;
        logic [3:0]  xidx;
        logic        xmiss;
        logic [70:0] xent;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int lat;
        int n;
        logic [3:0] widx;
        logic [70:0] went;
        logic [70:0] e5, e3, e9, eb;
        logic [70:0] old7;
        logic [1:0] rc;
        logic [18:0] rv;

        e5 = {19'h01234, 26'h2AAAAAA, 26'h1555555};
        e3 = {19'h00ABC, 26'h0000011, 26'h0000022};
        e9 = {19'h00ABC, 26'h0000033, 26'h0000044};
        tbl[0] = '{OP_WI, 4'd5, 19'h01234, 26'h2AAAAAA, 26'h1555555, 2, 4'd5, 1'b1, e5};
        tbl[1] = '{OP_WI, 4'd3, 19'h00ABC, 26'h0000011, 26'h0000022, 2, 4'd3, 1'b1, e3};
        tbl[2] = '{OP_WI, 4'd9, 19'h00ABC, 26'h0000033, 26'h0000044, 2, 4'd9, 1'b1, e9};
        tbl[3] = '{OP_P,  4'd0, 19'h00ABC, 26'h0, 26'h0, 5,  4'd3, 1'b0, '0};
        tbl[4] = '{OP_R,  4'd9, 19'h0,     26'h0, 26'h0, 2,  4'd0, 1'b0, e9};
        tbl[5] = '{OP_P,  4'd0, 19'h7FFFF, 26'h0, 26'h0, 17, 4'd3, 1'b1, '0};
        tbl[6] = '{OP_P,  4'd0, 19'h01234, 26'h0, 26'h0, 7,  4'd5, 1'b0, '0};
        tbl[7] = '{OP_P,  4'd0, 19'h00000, 26'h0, 26'h0, 2,  4'd0, 1'b0, '0};
        tbl[8] = '{OP_R,  4'd5, 19'h0,     26'h0, 26'h0, 2,  4'd0, 1'b0, e5};

        for (int k = 0; k < 16; k++) begin
            mem[k] = '0;
            ref_mem[k] = '0;
        end

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_op_ready", 71'(op_ready), 71'(1));
        chk("rst_busy", 71'(busy), 71'(0));
        chk("rst_done", 71'(done), 71'(0));
        chk("rst_tlb_we", 71'(tlb_we), 71'(0));
        chk("rst_wr_index", 71'(tlb_wr_index), 71'(0));
        chk("rst_wr_entry", tlb_wr_entry, 71'(0));
        chk("rst_rd_index", 71'(tlb_rd_index), 71'(0));
        chk("rst_rd_entry", rd_entry_out, 71'(0));
        chk("rst_probe_miss", 71'(probe_miss), 71'(1));
        chk("rst_probe_index", 71'(probe_index), 71'(0));
        chk("rst_random", 71'(random_out), 71'(15));
        chk("rst_wired", 71'(wired_out), 71'(0));
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Random sequence after reset: 15..0 then 15
        for (int i = 0; i <= 16; i++) begin
            chk("random_seq", 71'(random_out), 71'((i == 16) ? 15 : 15 - i));
            step();
        end

        // Table-driven ops
        for (int i = 0; i < 9; i++) begin
            do_and_check(tbl[i].code, tbl[i].idx, tbl[i].vpn, tbl[i].l1, tbl[i].l0, lat, widx, went);
            chk("tbl_latency", 71'(lat), 71'(tbl[i].lat));
            if (tbl[i].code == OP_WI) begin
                chk("tbl_wr_index", 71'(widx), 71'(tbl[i].xidx));
                chk("tbl_wr_entry", went, tbl[i].xent);
            end else if (tbl[i].code == OP_P) begin
                chk("tbl_probe_index", 71'(probe_index), 71'(tbl[i].xidx));
                chk("tbl_probe_miss", 71'(probe_miss), 71'(tbl[i].xmiss));
            end else begin
                chk("tbl_rd_entry", rd_entry_out, tbl[i].xent);
            end
        end
        step();

        // Wired = 12: Random 15,14,13,12,15, then TLBWR at Random = 13
        wired_we = 1'b1;
        wired_in = 4'd12;
        step();
        chk("wired12_val", 71'(wired_out), 71'(12));
        for (int i = 0; i < 5; i++) begin
            chk("wired12_seq", 71'(random_out), 71'((i == 4) ? 15 : 15 - i));
            if (i < 4) step();
        end
        n = 0;
        while (random_out != 4'd13 && n < 8) begin
            step();
            n++;
        end
        chk("random_reach13", 71'(random_out), 71'(13));
        do_and_check(OP_WR, 4'd1, 19'h00BEE, 26'h0ABCDEF, 26'h0123456, lat, widx, went);
        chk("tlbwr_random13", 71'(widx), 71'(13));
        step();

        // Back-to-back with op_valid held
        eb = {19'h00777, 26'h0000777, 26'h0000888};
        op_valid = 1'b1;
        op_code = OP_WI;
        index_in = 4'd2;
        entryhi_vpn2 = 19'h00777;
        entrylo1 = 26'h0000777;
        entrylo0 = 26'h0000888;
        chk("b2b_ready_T", 71'(op_ready), 71'(1));
        step();
        chk("b2b_we_T1", 71'(tlb_we), 71'(1));
        chk("b2b_busy_T1", 71'(busy), 71'(1));
        step();
        chk("b2b_done_T2", 71'(done), 71'(1));
        chk("b2b_ready_T2", 71'(op_ready), 71'(0));
        step();
        chk("b2b_ready_T3", 71'(op_ready), 71'(1));
        chk("b2b_we_T3", 71'(tlb_we), 71'(0));
        step();
        chk("b2b_we_T4", 71'(tlb_we), 71'(1));
        chk("b2b_wr_index", 71'(tlb_wr_index), 71'(2));
        op_valid = 1'b0;
        step();
        chk("b2b_done_T5", 71'(done), 71'(1));
        step();
        ref_mem[2] = eb;

        // Async reset mid-TLBWI
        old7 = ref_mem[7];
        op_valid = 1'b1;
        op_code = OP_WI;
        index_in = 4'd7;
        entryhi_vpn2 = 19'h05555;
        entrylo1 = 26'h1111111;
        entrylo0 = 26'h2222222;
        chk("rstop_ready", 71'(op_ready), 71'(1));
        step();
        op_valid = 1'b0;
        chk("rstop_we_T1", 71'(tlb_we), 71'(1));
        #3;
        rst_n = 1'b0;
        #1;
        chk("rstop_we_drop", 71'(tlb_we), 71'(0));
        chk("rstop_busy", 71'(busy), 71'(0));
        chk("rstop_ready_idle", 71'(op_ready), 71'(1));
        chk("rstop_done", 71'(done), 71'(0));
        chk("rstop_random", 71'(random_out), 71'(15));
        chk("rstop_wired", 71'(wired_out), 71'(0));
        @(posedge clk);
        #1;
        chk("rstop_no_write", mem[7], old7);
        rst_n = 1'b1;
        pm_m = 1'b1;
        pi_m = 4'd0;
        rd_m = '0;
        step();
        chk("rstop_done_after", 71'(done), 71'(0));
        chk("rstop_busy_after", 71'(busy), 71'(0));

        // Randomized ops against the reference model
        rand_wired = 1'b1;
        for (int i = 0; i < 60; i++) begin
            rc = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: rv = 19'h00ABC;
                1: rv = 19'h01234;
                2: rv = 19'h00777;
                default: rv = 19'($urandom_range(0, 3));
            endcase
            do_and_check(rc, 4'($urandom_range(0, 15)), rv,
                         26'($urandom), 26'($urandom), lat, widx, went);
        end
        rand_wired = 1'b0;
        step();
        step();

        for (int k = 0; k < 16; k++) begin
            chk("final_mem", mem[k], ref_mem[k]);
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
